// File: rtl/run_sequencer.sv
// Run controller: start/pause/resume/abort of a cycle count ending at a programmable limit,
// with milestone hit pulses. Optional RUN_SEQ_FINISH_EN ends simulation when the run completes.
module run_sequencer #(
  parameter int               CNT_W         = 32,
  parameter int               NUM_MARKS     = 4,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(99)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       pause_i,
  input  logic                       abort_i,
  input  logic                       limit_we_i,
  input  logic [CNT_W-1:0]           limit_i,
  input  logic [NUM_MARKS-1:0]       mark_en_i,
  input  logic [NUM_MARKS*CNT_W-1:0] mark_val_i,
  output logic [CNT_W-1:0]           count_o,
  output logic [1:0]                 state_o,
  output logic                       done_o,
  output logic [NUM_MARKS-1:0]       mark_hit_o,
  output logic [NUM_MARKS-1:0]       mark_seen_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     limit_q, limit_d;
  logic                 done_q, done_d;
  logic [NUM_MARKS-1:0] hit_q, hit_d;
  logic [NUM_MARKS-1:0] seen_q, seen_d;
  logic                 fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= DEFAULT_LIMIT;
      done_q  <= 1'b0;
      hit_q   <= '0;
      seen_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    hit_d   = '0;
    seen_d  = seen_q;
    fire    = 1'b0;

    // Limit is only writable between runs, so a run never sees it change underneath it.
    if (limit_we_i && (state_q == IDLE || state_q == DONE))
      limit_d = limit_i;

    if (abort_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_d = RUN;
            count_d = '0;
            seen_d  = '0;
          end
        end
        RUN: begin
          if (count_q == limit_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            fire    = 1'b1;
          end else if (pause_i) begin
            state_d = PAUSE;
          end else begin
            count_d = count_q + CNT_W'(1);
            fire    = 1'b1;
          end
        end
        PAUSE: begin
          if (!pause_i)
            state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    // Only counting or terminating RUN cycles compare, so each value fires once per run.
    if (fire) begin
      for (int i = 0; i < NUM_MARKS; i++) begin
        if (mark_en_i[i] && count_q == mark_val_i[i*CNT_W +: CNT_W]) begin
          hit_d[i]  = 1'b1;
          seen_d[i] = 1'b1;
        end
      end
    end
  end

  assign count_o     = count_q;
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign mark_hit_o  = hit_q;
  assign mark_seen_o = seen_q;

`ifdef RUN_SEQ_FINISH_EN
  always_ff @(posedge clk) begin
    if (done_q) begin
      $write("*-* All Finished *-*\n");
      $finish;
    end
  end
`else
  // Run completion is observed by the environment through done_o.
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer: default run, limits, pause, marks, abort, reset.
module tb_run_sequencer;
  localparam int CNT_W     = 32;
  localparam int NUM_MARKS = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start_i;
  logic                       pause_i;
  logic                       abort_i;
  logic                       limit_we_i;
  logic [CNT_W-1:0]           limit_i;
  logic [NUM_MARKS-1:0]       mark_en_i;
  logic [NUM_MARKS*CNT_W-1:0] mark_val_i;
  logic [CNT_W-1:0]           count_o;
  logic [1:0]                 state_o;
  logic                       done_o;
  logic [NUM_MARKS-1:0]       mark_hit_o;
  logic [NUM_MARKS-1:0]       mark_seen_o;

  int n_cmp = 0;
  int n_err = 0;

  run_sequencer #(.CNT_W(CNT_W), .NUM_MARKS(NUM_MARKS)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .pause_i(pause_i), .abort_i(abort_i),
    .limit_we_i(limit_we_i), .limit_i(limit_i), .mark_en_i(mark_en_i), .mark_val_i(mark_val_i),
    .count_o(count_o), .state_o(state_o), .done_o(done_o), .mark_hit_o(mark_hit_o),
    .mark_seen_o(mark_seen_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] cnt,
                           input logic dn, input logic [3:0] hit, input logic [3:0] seen);
    check({tag, ".state"}, 64'(state_o), 64'(st));
    check({tag, ".count"}, 64'(count_o), 64'(cnt));
    check({tag, ".done"},  64'(done_o),  64'(dn));
    check({tag, ".hit"},   64'(mark_hit_o),  64'(hit));
    check({tag, ".seen"},  64'(mark_seen_o), 64'(seen));
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; pause_i = 1'b0; abort_i = 1'b0;
    limit_we_i = 1'b0; limit_i = '0; mark_en_i = '0;
    mark_val_i = {32'd30, 32'd10, 32'd3, 32'd3};
    step(); step();
    reset = 1'b0;
    check_all("reset", 2'd0, 0, 1'b0, 4'h0, 4'h0);
    step();
    check_all("idle_hold", 2'd0, 0, 1'b0, 4'h0, 4'h0);

    // Default limit 99 run
    start_i = 1'b1; step(); start_i = 1'b0;
    check("def_start_state", 64'(state_o), 64'd1);
    for (int k = 0; k < 99; k++) begin
      check("def_count", 64'(count_o), 64'(k));
      check("def_nodone", 64'(done_o), 64'd0);
      step();
    end
    check_all("def_at99", 2'd1, 99, 1'b0, 4'h0, 4'h0);
    step();
    check_all("def_done", 2'd3, 99, 1'b1, 4'h0, 4'h0);
    step();
    check_all("def_done_hold", 2'd3, 99, 1'b0, 4'h0, 4'h0);

    // Abort from DONE, then limit 5 loaded in IDLE
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check_all("abort_done", 2'd0, 0, 1'b0, 4'h0, 4'h0);
    limit_we_i = 1'b1; limit_i = 32'd5; step(); limit_we_i = 1'b0;
    check("lim5_idle", 64'(state_o), 64'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    check("lim5_c0", 64'(count_o), 64'd0);
    repeat (5) step();
    check_all("lim5_at5", 2'd1, 5, 1'b0, 4'h0, 4'h0);
    step();
    check_all("lim5_done", 2'd3, 5, 1'b1, 4'h0, 4'h0);
    step();
    check_all("lim5_hold", 2'd3, 5, 1'b0, 4'h0, 4'h0);

    // Limit 20 loaded together with start in DONE; marks {3,3,10,30}; pause at 7
    mark_en_i = 4'hF;
    limit_we_i = 1'b1; limit_i = 32'd20; start_i = 1'b1; step();
    limit_we_i = 1'b0; start_i = 1'b0;
    check_all("m_start", 2'd1, 0, 1'b0, 4'h0, 4'h0);
    repeat (3) step();
    check_all("m_at3", 2'd1, 3, 1'b0, 4'h0, 4'h0);
    step();
    check_all("m_hit01", 2'd1, 4, 1'b0, 4'h3, 4'h3);
    step();
    check_all("m_at5", 2'd1, 5, 1'b0, 4'h0, 4'h3);
    repeat (2) step();
    check("p_at7", 64'(count_o), 64'd7);
    pause_i = 1'b1;
    step(); check_all("p_1", 2'd2, 7, 1'b0, 4'h0, 4'h3);
    step(); check_all("p_2", 2'd2, 7, 1'b0, 4'h0, 4'h3);
    step(); check_all("p_3", 2'd2, 7, 1'b0, 4'h0, 4'h3);
    pause_i = 1'b0;
    step(); check_all("p_resume", 2'd1, 7, 1'b0, 4'h0, 4'h3);
    step(); check_all("p_at8", 2'd1, 8, 1'b0, 4'h0, 4'h3);
    repeat (2) step();
    check_all("m_at10", 2'd1, 10, 1'b0, 4'h0, 4'h3);
    step();
    check_all("m_hit2", 2'd1, 11, 1'b0, 4'h4, 4'h7);
    repeat (9) step();
    check_all("m_at20", 2'd1, 20, 1'b0, 4'h0, 4'h7);
    step();
    check_all("m_done", 2'd3, 20, 1'b1, 4'h0, 4'h7);
    step();
    check_all("m_done_hold", 2'd3, 20, 1'b0, 4'h0, 4'h7);

    // Restart clears seen; mid-run limit/start ignored; abort at 12 keeps seen
    start_i = 1'b1; step(); start_i = 1'b0;
    check_all("r_start", 2'd1, 0, 1'b0, 4'h0, 4'h0);
    step();
    limit_we_i = 1'b1; limit_i = 32'd2; start_i = 1'b1; step();
    limit_we_i = 1'b0; start_i = 1'b0;
    check_all("r_ign_start", 2'd1, 2, 1'b0, 4'h0, 4'h0);
    step();
    check_all("r_ign_limit", 2'd1, 3, 1'b0, 4'h0, 4'h0);
    step();
    check_all("r_hit01", 2'd1, 4, 1'b0, 4'h3, 4'h3);
    repeat (8) step();
    check_all("r_at12", 2'd1, 12, 1'b0, 4'h0, 4'h7);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check_all("r_abort", 2'd0, 0, 1'b0, 4'h0, 4'h7);
    step();
    check_all("r_idle", 2'd0, 0, 1'b0, 4'h0, 4'h7);

    // Limit 0: done two cycles after start
    limit_we_i = 1'b1; limit_i = 32'd0; start_i = 1'b1; step();
    limit_we_i = 1'b0; start_i = 1'b0;
    check_all("z_run", 2'd1, 0, 1'b0, 4'h0, 4'h0);
    step();
    check_all("z_done", 2'd3, 0, 1'b1, 4'h0, 4'h0);

    // Reset while paused
    limit_we_i = 1'b1; limit_i = 32'd50; start_i = 1'b1; step();
    limit_we_i = 1'b0; start_i = 1'b0;
    repeat (4) step();
    check_all("x_at4", 2'd1, 4, 1'b0, 4'h3, 4'h3);
    pause_i = 1'b1; step();
    check_all("x_pause", 2'd2, 4, 1'b0, 4'h0, 4'h3);
    reset = 1'b1; step(); reset = 1'b0; pause_i = 1'b0;
    check_all("x_reset", 2'd0, 0, 1'b0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
